// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared FSM state type, forwarding selects and forwarding helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        HOLD     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    // The younger producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       exm_we,
        input logic [4:0] exm_dest,
        input logic       mwb_we,
        input logic [4:0] mwb_dest
    );
        if (exm_we && (exm_dest != 5'd0) && (exm_dest == src))
            return FWD_EX_MEM;
        else if (mwb_we && (mwb_dest != 5'd0) && (mwb_dest == src))
            return FWD_MEM_WB;
        else
            return FWD_REG;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// forward_unit : combinational EX-stage operand forwarding selects
// Revision : 1.0
// ============================================================================
`default_nettype none

module forward_unit
    import mips_pkg::*;
(
    input  logic [4:0] id_ex_rs,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] ex_mem_dest,
    input  logic [4:0] mem_wb_dest,
    input  logic       ex_mem_reg_write,
    input  logic       mem_wb_reg_write,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    assign forward_a = fwd_sel(id_ex_rs, ex_mem_reg_write, ex_mem_dest,
                               mem_wb_reg_write, mem_wb_dest);
    assign forward_b = fwd_sel(id_ex_rt, ex_mem_reg_write, ex_mem_dest,
                               mem_wb_reg_write, mem_wb_dest);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : load-use stall, branch flush, freeze handshake and counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [4:0]       id_ex_rs,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       ex_mem_dest,
    input  logic [4:0]       mem_wb_dest,
    input  logic             ex_mem_reg_write,
    input  logic             mem_wb_reg_write,
    input  logic             branch_taken,
    input  logic             ext_stall_req,
    input  logic             clear_counters,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             pipe_hold,
    output logic             ext_stall_ack,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [3:0]       LD_EXTRA = 4'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;
    logic             do_flush;

    forward_unit u_forward_unit (
        .id_ex_rs         (id_ex_rs),
        .id_ex_rt         (id_ex_rt),
        .ex_mem_dest      (ex_mem_dest),
        .mem_wb_dest      (mem_wb_dest),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .forward_a        (forward_a),
        .forward_b        (forward_b)
    );

    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        do_flush      = 1'b0;
        pipe_hold     = 1'b0;
        ext_stall_ack = 1'b0;
        // Outputs are forced to their idle values while reset is held.
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        do_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            state_d  = LD_STALL;
                            remain_d = LD_EXTRA;
                        end
                    end else if (ext_stall_req) begin
                        state_d = HOLD;
                    end
                end
                LD_STALL: begin
                    if (branch_taken) begin
                        do_flush = 1'b1;
                        state_d  = RUN;
                        remain_d = 4'd0;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (remain_q <= 4'd1) begin
                            state_d  = RUN;
                            remain_d = 4'd0;
                        end else begin
                            remain_d = remain_q - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    pipe_hold     = 1'b1;
                    ext_stall_ack = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    if (!ext_stall_req) state_d = RUN;
                end
                default: begin
                    state_d  = RUN;
                    remain_d = 4'd0;
                end
            endcase
        end
    end

    assign flush_if_id  = do_flush;
    assign flush_id_ex  = do_flush;
    assign flush_ex_mem = do_flush;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (clear_counters) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_write && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
            if (do_flush && (flush_q != '1))  flush_d = flush_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            remain_q <= 4'd0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS datapath. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and makes three kinds of decision:
- forwarding selects for the EX-stage ALU operands;
- load-use stalls, including multi-cycle stalls for slow data memory;
- flushes when a branch is taken.

It also arbitrates an external freeze request through a request/acknowledge handshake, and it keeps saturating stall and flush counters.

## Interface
Parameters:
- LOAD_LATENCY, default 1: number of bubble cycles inserted per load-use hazard. Legal range is 1–15.
- CNT_W, default 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_id_rs, if_id_rt  in  5 each  source registers of the instruction in ID.
- if_id_uses_rt  in  1  the ID instruction reads rt (R-type, beq, sw).
- id_ex_rs, id_ex_rt  in  5 each  source registers of the instruction in EX.
- id_ex_mem_read  in  1  the EX instruction is a load.
- ex_mem_dest, mem_wb_dest  in  5 each  destination registers in MEM and in WB.
- ex_mem_reg_write, mem_wb_reg_write  in  1 each  register-write enables for those stages.
- branch_taken  in  1  ctrl_pcSrc, resolved in MEM.
- ext_stall_req  in  1  request to freeze the whole pipeline.
- clear_counters  in  1  synchronous clear of both counters.
- pc_write, if_id_write  out  1 each  enables for the PC and IF/ID registers.
- id_ex_bubble  out  1  zeroes the ID/EX control fields.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear the named pipeline register.
- pipe_hold  out  1  freezes every pipeline register and gates data-memory and register-file writes.
- ext_stall_ack  out  1  the pipeline is frozen.
- forward_a, forward_b  out  2 each  operand source selects.
- state  out  2  current FSM state.
- stall_cycles, flush_events  out  CNT_W each  performance counters.

## Operation
- Forwarding is combinational and evaluated identically in every state. Rules for forward_a:
  - EX_MEM (2'b10) if ex_mem_reg_write, ex_mem_dest≠0 and ex_mem_dest==id_ex_rs;
  - otherwise MEM_WB (2'b01) under the same conditions using the mem_wb_* signals;
  - otherwise REG (2'b00).
  - forward_b applies the same rules using id_ex_rt.
- The load-use condition is true when id_ex_mem_read is set, id_ex_rt≠0, and id_ex_rt matches either if_id_rs or (if_id_uses_rt and if_id_rt).
- Three FSM states: RUN=0, LD_STALL=1, HOLD=2.
- RUN, evaluated in priority order:
  1. branch_taken: assert all three flush outputs this cycle, increment flush_events, remain in RUN. A simultaneous load-use or request is ignored for this cycle.
  2. load-use: set pc_write=0, if_id_write=0 and id_ex_bubble=1 this cycle. If LOAD_LATENCY>1, go to LD_STALL with the remaining count set to LOAD_LATENCY-1.
  3. ext_stall_req: go to HOLD.
- LD_STALL:
  - Keep the same stall outputs asserted.
  - Decrement the remaining count each cycle; return to RUN after the cycle in which the count reaches 1.
  - ext_stall_req is not accepted in this state.
  - branch_taken aborts the stall: assert the flushes, deassert the stall outputs, return to RUN.
- HOLD:
  - pipe_hold=1, ext_stall_ack=1, pc_write=0, if_id_write=0; no flush and no bubble is issued.
  - branch_taken is deferred: the registers are frozen, so it reappears once HOLD exits.
  - When ext_stall_req=0, return to RUN.
- stall_cycles increments on every cycle with pc_write=0. flush_events increments on every branch flush.
- Both counters saturate at all-ones. clear_counters wins over a same-cycle increment.

## Timing
- During reset (reset=0):
  - state=RUN, both counters 0, LD_STALL count 0;
  - pc_write=1, if_id_write=1;
  - all flush, bubble, hold and ack outputs 0.
- Stall, flush and forwarding outputs are combinational from the inputs and the state, so they take effect on the same clock edge.
- Load-use costs exactly LOAD_LATENCY cycles.
- HOLD handshake:
  - ext_stall_req sampled high in RUN at edge N gives ext_stall_ack=1 from cycle N+1.
  - With ext_stall_req low at edge M, ack drops in cycle M+1.
  - The minimum hold is one cycle.
- An asynchronous reset in LD_STALL or HOLD returns to RUN immediately; there is no residual stall.

## Structure
- mips_pkg holds:
  - the state typedef enum {RUN, LD_STALL, HOLD};
  - the forward-select constants FWD_REG, FWD_MEM_WB, FWD_EX_MEM.
- One natural sub-module: forward_unit, the purely combinational forward_a/forward_b logic.
- The FSM, the stall counter and the performance counters live in hazard_ctrl.

## Test plan
- lw $2 in EX, add $3,$2,$4 in ID, LOAD_LATENCY=1 → one cycle with pc_write=0 and id_ex_bubble=1, then state stays RUN; stall_cycles=1.
- Same hazard with LOAD_LATENCY=3 → three stall cycles, state sequence RUN, LD_STALL, LD_STALL, RUN; stall_cycles=3.
- ex_mem_dest=5 and mem_wb_dest=5 (both writing), id_ex_rs=5 → forward_a=2'b10. Same with dest=0 → 2'b00.
- branch_taken together with a load-use hazard → all three flushes asserted, no stall, flush_events=1.
- ext_stall_req high for 4 cycles, branch_taken asserted mid-hold → ack high for 4 cycles, no flush until the cycle after ack drops, then flushes assert.
- Reset asserted mid-LD_STALL, then stall_cycles driven to saturation with clear_counters pulsed → state=RUN immediately and counters=0; the counter then holds at 16'hFFFF and clears to 0 on the pulse.
